// File: rtl/key_conditioner_pkg.sv
// Shared constants for the push-button front end.
//   BTN_*        : bit positions of each button inside btn_raw
//   rep_state_e  : auto-repeat FSM states
//   max3()       : helper used to size the per-channel counters
package key_conditioner_pkg;

  localparam int NUM_BTN   = 6;
  localparam int BTN_MODE  = 0;
  localparam int BTN_BIT   = 1;
  localparam int BTN_ADD   = 2;
  localparam int BTN_SUB   = 3;
  localparam int BTN_SET   = 4;
  localparam int BTN_CLEAR = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } rep_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Button / command bundle between the board buttons and the control block.
//   en         : global enable
//   btn_raw    : raw asynchronous buttons [mode,bit,add,sub,set,clear]
//   mod_choose .. clear : single-cycle command pulses
//   any_held   : OR of all debounced levels
// master = button/stimulus side, slave = conditioner.
interface key_conditioner_if;
  import key_conditioner_pkg::*;

  logic               en;
  logic [NUM_BTN-1:0] btn_raw;
  logic               mod_choose;
  logic               bit_choose;
  logic               val_add;
  logic               val_sub;
  logic               val_set;
  logic               clear;
  logic               any_held;

  modport master (
    output en, btn_raw,
    input  mod_choose, bit_choose, val_add, val_sub, val_set, clear, any_held
  );

  modport slave (
    input  en, btn_raw,
    output mod_choose, bit_choose, val_add, val_sub, val_set, clear, any_held
  );

endinterface

// File: rtl/key_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, stable level,
// and a press/auto-repeat FSM.
//   clk, reset : system clock, async active-low reset
//   i_en       : enable; low holds debounce and FSM in reset (sync keeps running)
//   i_raw      : raw asynchronous button
//   o_fire     : combinational "pulse next edge" request (registered by the top)
//   o_stable   : debounced level
// With REPEAT_EN=0 the FSM never leaves IDLE, so only the press fires.
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_raw,
  output logic o_fire,
  output logic o_stable
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_db_cnt;
  logic          r_stable;
  logic          r_stable_d;
  logic          w_samp;
  logic          w_rise;

  rep_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic          w_fire;

  // Synchroniser runs regardless of i_en so a held button is seen at once on re-enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_raw};
  end

  assign w_samp = r_sync[1];

  // Level only toggles after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_cnt   <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else if (!i_en) begin
      r_db_cnt   <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      if (w_samp == r_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_stable <= ~r_stable;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_rise = r_stable & ~r_stable_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rep_cnt <= '0;
    end else if (!i_en) begin
      r_state   <= IDLE;
      r_rep_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
    end
  end

  // A stable fall wins over a due repeat so nothing fires after release.
  always_comb begin
    w_state_nxt   = r_state;
    w_rep_cnt_nxt = r_rep_cnt;
    w_fire        = 1'b0;
    case (r_state)
      IDLE: begin
        w_rep_cnt_nxt = '0;
        if (w_rise) begin
          w_fire = 1'b1;
          if (REPEAT_EN) w_state_nxt = WAIT_HOLD;
        end
      end
      WAIT_HOLD: begin
        if (!r_stable) begin
          w_state_nxt   = IDLE;
          w_rep_cnt_nxt = '0;
        end else if (r_rep_cnt == HLD_LAST) begin
          w_fire        = 1'b1;
          w_state_nxt   = REPEAT;
          w_rep_cnt_nxt = '0;
        end else begin
          w_rep_cnt_nxt = r_rep_cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!r_stable) begin
          w_state_nxt   = IDLE;
          w_rep_cnt_nxt = '0;
        end else if (r_rep_cnt == REP_LAST) begin
          w_fire        = 1'b1;
          w_rep_cnt_nxt = '0;
        end else begin
          w_rep_cnt_nxt = r_rep_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_rep_cnt_nxt = '0;
      end
    endcase
  end

  assign o_fire   = w_fire & i_en;
  assign o_stable = r_stable;

endmodule

// File: rtl/key_conditioner.sv
// Six-button conditioner: synchronise, debounce, and pulse once per press;
// add/sub auto-repeat while held.
//   clk   : system clock
//   reset : async active-low reset
//   bus   : key_conditioner_if.slave (en, btn_raw in; command pulses, any_held out)
// Simultaneous add+sub fires cancel each other for that cycle only.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              reset,
  key_conditioner_if.slave  bus
);

  logic [NUM_BTN-1:0] w_fire;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_pulse_nxt;
  logic [NUM_BTN-1:0] r_pulse;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (g == BTN_ADD || g == BTN_SUB)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_en     (bus.en),
      .i_raw    (bus.btn_raw[g]),
      .o_fire   (w_fire[g]),
      .o_stable (w_stable[g])
    );
  end

  always_comb begin
    w_pulse_nxt = w_fire;
    if (w_fire[BTN_ADD] && w_fire[BTN_SUB]) begin
      w_pulse_nxt[BTN_ADD] = 1'b0;
      w_pulse_nxt[BTN_SUB] = 1'b0;
    end
    if (!bus.en) w_pulse_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pulse <= '0;
    else        r_pulse <= w_pulse_nxt;
  end

  // Extra en gate so a pulse already registered is dropped the moment en falls.
  assign bus.mod_choose = r_pulse[BTN_MODE]  & bus.en;
  assign bus.bit_choose = r_pulse[BTN_BIT]   & bus.en;
  assign bus.val_add    = r_pulse[BTN_ADD]   & bus.en;
  assign bus.val_sub    = r_pulse[BTN_SUB]   & bus.en;
  assign bus.val_set    = r_pulse[BTN_SET]   & bus.en;
  assign bus.clear      = r_pulse[BTN_CLEAR] & bus.en;
  assign bus.any_held   = |w_stable;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with D=4, H=10, R=4.
// The model works on recorded per-edge history: a level flips when the last D
// synchronised samples (all taken while enabled) disagree with it; pulses are
// scheduled at fixed offsets from the press edge.
module tb_key_conditioner;
  import key_conditioner_pkg::*;

  localparam int D = 4, H = 10, R = 4, MAXC = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_conditioner_if kif();

  key_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif)
  );

  int total = 0, bad = 0, cyc = 0;

  logic [5:0] raw_h [MAXC];
  bit         rok   [MAXC];
  bit         okw   [MAXC];
  logic [5:0] sm    [MAXC];
  bit         st    [6];
  bit         pv    [6];
  int         pe    [6];
  logic [5:0] m_out  = '0;
  bit         m_held = 1'b0;

  int pcnt [6];
  int add_q [$];

  // Behavioural model, advanced once per rising edge.
  always @(posedge clk) begin : model_p
    logic [5:0] f;
    int  k;
    bit  flip;
    cyc = cyc + 1;
    if (cyc < MAXC) begin
      raw_h[cyc] = kif.btn_raw;
      rok[cyc]   = reset;
      okw[cyc]   = reset && kif.en;
      for (int c = 0; c < 6; c++)
        sm[cyc][c] = (cyc >= 3 && rok[cyc-1] && rok[cyc-2]) ? raw_h[cyc-2][c] : 1'b0;
      f = '0;
      for (int c = 0; c < 6; c++) begin
        if (okw[cyc] && st[c] && pv[c]) begin
          k = cyc - pe[c];
          if (k == 0) f[c] = 1'b1;
          else if ((c == 2 || c == 3) && k >= H && ((k - H) % R) == 0) f[c] = 1'b1;
        end
      end
      for (int c = 0; c < 6; c++) begin
        if (!okw[cyc]) begin
          st[c] = 1'b0;
          pv[c] = 1'b0;
        end else begin
          flip = 1'b1;
          for (int j = 0; j < D; j++)
            if (cyc - j < 1 || !okw[cyc-j] || sm[cyc-j][c] == st[c]) flip = 1'b0;
          if (flip) begin
            st[c] = !st[c];
            pv[c] = st[c];
            pe[c] = cyc + 1;
          end
        end
      end
      if (f[2] && f[3]) f[3:2] = 2'b00;
      m_out  = f;
      m_held = 1'b0;
      for (int c = 0; c < 6; c++) if (st[c]) m_held = 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp_p
    logic [5:0] dv, ev;
    bit eh;
    dv = {kif.clear, kif.val_set, kif.val_sub, kif.val_add, kif.bit_choose, kif.mod_choose};
    ev = (reset && kif.en) ? m_out : 6'b0;
    eh = reset ? m_held : 1'b0;
    total++;
    if (dv !== ev) begin
      bad++;
      $display("FAIL pulses edge=%0d got=%b exp=%b", cyc, dv, ev);
    end
    total++;
    if (kif.any_held !== eh) begin
      bad++;
      $display("FAIL any_held edge=%0d got=%b exp=%b", cyc, kif.any_held, eh);
    end
    for (int i = 0; i < 6; i++) if (dv[i] === 1'b1) pcnt[i]++;
    if (dv[2] === 1'b1) add_q.push_back(cyc);
  end

  task automatic lit(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int a, r0, e0, c0, c2, c3, c4;
    int offs [9];
    offs = '{0, 10, 14, 18, 22, 26, 30, 34, 38};

    reset       = 1'b0;
    kif.en      = 1'b1;
    kif.btn_raw = '0;
    #1;
    lit("rst_any_held", int'(kif.any_held), 0);
    lit("rst_pulses", int'({kif.clear, kif.val_set, kif.val_sub, kif.val_add,
                            kif.bit_choose, kif.mod_choose}), 0);
    step(2);
    reset = 1'b1;

    // Set press: raw rises before edge 10, pulse only after edge 16.
    step(7);
    kif.btn_raw[4] = 1'b1;
    step(6);
    lit("set_edge15", int'(kif.val_set), 0);
    step(1);
    lit("set_edge16", int'(kif.val_set), 1);
    step(1);
    lit("set_edge17", int'(kif.val_set), 0);
    step(15);
    lit("set_once", pcnt[4], 1);
    lit("set_held", int'(kif.any_held), 1);
    kif.btn_raw[4] = 1'b0;
    step(10);
    lit("set_released", int'(kif.any_held), 0);

    // Three-cycle glitch on mode.
    c0 = pcnt[0];
    kif.btn_raw[0] = 1'b1;
    step(3);
    kif.btn_raw[0] = 1'b0;
    step(10);
    lit("glitch_mode", pcnt[0] - c0, 0);

    // Bouncing clear press.
    c0 = pcnt[5];
    for (int i = 0; i < 6; i++) begin
      kif.btn_raw[5] = (i % 2 == 0);
      step(2);
    end
    kif.btn_raw[5] = 1'b1;
    step(12);
    lit("bounce_clear", pcnt[5] - c0, 1);
    kif.btn_raw[5] = 1'b0;
    step(10);

    // Add held 40 cycles: pulses at p, p+10, p+14, ...
    add_q.delete();
    a = cyc;
    kif.btn_raw[2] = 1'b1;
    step(40);
    kif.btn_raw[2] = 1'b0;
    step(12);
    lit("add_first_edge", (add_q.size() > 0) ? add_q[0] : -1, a + 7);
    lit("add_count", add_q.size(), 9);
    for (int i = 0; i < 9; i++)
      lit($sformatf("add_off%0d", i),
          (add_q.size() > i) ? add_q[i] - add_q[0] : -1, offs[i]);

    // Add and sub together: every fire coincides and cancels.
    c2 = pcnt[2];
    c3 = pcnt[3];
    kif.btn_raw[3:2] = 2'b11;
    step(30);
    kif.btn_raw[3:2] = 2'b00;
    step(12);
    lit("conflict_add", pcnt[2] - c2, 0);
    lit("conflict_sub", pcnt[3] - c3, 0);

    // Reset mid-repeat on sub.
    kif.btn_raw[3] = 1'b1;
    step(25);
    reset = 1'b0;
    #1;
    lit("rst_mid_sub", int'(kif.val_sub), 0);
    lit("rst_mid_held", int'(kif.any_held), 0);
    step(3);
    reset = 1'b1;
    r0 = cyc;
    step(D + 2);
    lit("sub_before_press", int'(kif.val_sub), 0);
    step(1);
    lit("sub_after_reset", int'(kif.val_sub), 1);
    step(H);
    lit("sub_first_repeat", int'(kif.val_sub), 1);
    lit("sub_edge_ref", cyc - r0, D + 3 + H);
    kif.btn_raw[3] = 1'b0;
    step(12);

    // en low: no pulses, then a held button presses afresh on re-enable.
    c2 = pcnt[2];
    c4 = pcnt[4];
    kif.en = 1'b0;
    kif.btn_raw[4] = 1'b1;
    kif.btn_raw[2] = 1'b1;
    step(20);
    lit("en_low_set", pcnt[4] - c4, 0);
    lit("en_low_add", pcnt[2] - c2, 0);
    lit("en_low_held", int'(kif.any_held), 0);
    kif.en = 1'b1;
    e0 = cyc;
    step(D);
    lit("en_set_early", int'(kif.val_set), 0);
    step(1);
    lit("en_set_press", int'(kif.val_set), 1);
    lit("en_add_press", int'(kif.val_add), 1);
    lit("en_press_edge", cyc - e0, D + 1);
    kif.btn_raw = '0;
    step(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
